// File: rtl/arcade_input_ctrl.sv
// Input/pause conditioning for the arcade core: joystick mapping, coin pulse shaping, pause toggle, pixel register.
// Optional feature macro: INPUT_PAUSE_DIM_EN builds the long-pause dim counter and pixel dimming.
module arcade_input_ctrl #(
    parameter int COIN_PULSE  = 400000,
    parameter int COIN_GAP    = 240000,
    parameter int DIM_TIMEOUT = 240000000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        osd_status,
    input  logic        osd_pause_dis,
    input  logic        hs_access,
    input  logic [7:0]  rgb_in,
    output logic        m_up,
    output logic        m_down,
    output logic        m_left,
    output logic        m_right,
    output logic        m_fire,
    output logic        m_start1,
    output logic        m_start2,
    output logic        m_coin1,
    output logic        m_coin2,
    output logic        pause,
    output logic        dim_video,
    output logic [7:0]  rgb_out
);

    localparam int COIN_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int COIN_W   = (COIN_MAX > 1) ? $clog2(COIN_MAX) : 1;
    localparam logic [COIN_W-1:0] PULSE_LOAD = COIN_W'(COIN_PULSE - 1);
    localparam logic [COIN_W-1:0] GAP_LOAD   = COIN_W'((COIN_GAP > 0) ? COIN_GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } coin_state_t;

    logic [15:0] w_joy;
    logic [1:0]  w_coin_raw;
    logic [1:0]  w_coin;
    logic [6:0]  r_ctrl;
    logic        r_joy8_prev;
    logic        r_toggle;
    logic        w_toggle_next;
    logic        r_pause;
    logic        w_unused;

    assign w_joy      = joystick_0 | joystick_1;
    assign w_coin_raw = {joystick_1[7], joystick_0[7]};
    assign w_unused   = ^{w_joy[15:9], w_joy[7]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_coin
            coin_state_t       r_state, w_state_next;
            logic [COIN_W-1:0] r_cnt, w_cnt_next;
            logic              r_prev, r_armed, r_coin, w_coin_next, w_edge;

            // r_armed blocks a button held through reset from firing until it has been seen released
            assign w_edge    = w_coin_raw[gi] & ~r_prev & r_armed;
            assign w_coin[gi] = r_coin;

            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_prev  <= 1'b0;
                    r_armed <= 1'b0;
                    r_coin  <= 1'b0;
                end else begin
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                    r_prev  <= w_coin_raw[gi];
                    r_armed <= r_armed | ~w_coin_raw[gi];
                    r_coin  <= w_coin_next;
                end
            end

            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                w_coin_next  = r_coin;
                case (r_state)
                    S_IDLE: begin
                        if (w_edge) begin
                            w_state_next = S_PULSE;
                            w_cnt_next   = PULSE_LOAD;
                            w_coin_next  = 1'b1;
                        end
                    end
                    S_PULSE: begin
                        if (r_cnt == '0) begin
                            w_coin_next = 1'b0;
                            if (COIN_GAP == 0) begin
                                w_state_next = S_IDLE;
                            end else begin
                                w_state_next = S_GAP;
                                w_cnt_next   = GAP_LOAD;
                            end
                        end else begin
                            w_cnt_next = r_cnt - COIN_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (r_cnt == '0) begin
                            w_state_next = S_IDLE;
                        end else begin
                            w_cnt_next = r_cnt - COIN_W'(1);
                        end
                    end
                    default: begin
                        w_state_next = S_IDLE;
                        w_coin_next  = 1'b0;
                    end
                endcase
            end
        end
    endgenerate

    assign w_toggle_next = r_toggle ^ (w_joy[8] & ~r_joy8_prev);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl      <= '0;
            r_joy8_prev <= 1'b0;
            r_toggle    <= 1'b0;
            r_pause     <= 1'b0;
        end else begin
            r_ctrl      <= w_joy[6:0];
            r_joy8_prev <= w_joy[8];
            r_toggle    <= w_toggle_next;
            r_pause     <= hs_access | w_toggle_next | (osd_status & ~osd_pause_dis);
        end
    end

`ifdef INPUT_PAUSE_DIM_EN
    localparam int DIM_W = $clog2(DIM_TIMEOUT + 1);
    localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(DIM_TIMEOUT);

    logic [DIM_W-1:0] r_dim_cnt, w_dim_cnt_next;
    logic             r_dim;
    logic [7:0]       r_rgb;

    // only the user toggle counts; OSD and hiscore pauses never dim the picture
    always_comb begin
        w_dim_cnt_next = r_dim_cnt;
        if (!r_toggle) begin
            w_dim_cnt_next = '0;
        end else if (r_dim_cnt != DIM_MAX) begin
            w_dim_cnt_next = r_dim_cnt + DIM_W'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dim_cnt <= '0;
            r_dim     <= 1'b0;
            r_rgb     <= '0;
        end else begin
            r_dim_cnt <= w_dim_cnt_next;
            r_dim     <= (w_dim_cnt_next == DIM_MAX);
            r_rgb     <= r_dim ? {1'b0, rgb_in[7:6], 1'b0, rgb_in[4:3], 1'b0, rgb_in[1]} : rgb_in;
        end
    end

    assign dim_video = r_dim;
    assign rgb_out   = r_rgb;
`else
    localparam int UNUSED_DIM_TIMEOUT = DIM_TIMEOUT;

    logic [7:0] r_rgb;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= rgb_in;
        end
    end

    assign dim_video = 1'b0;
    assign rgb_out   = r_rgb;
`endif

    assign m_right  = r_ctrl[0];
    assign m_left   = r_ctrl[1];
    assign m_down   = r_ctrl[2];
    assign m_up     = r_ctrl[3];
    assign m_fire   = r_ctrl[4];
    assign m_start1 = r_ctrl[5];
    assign m_start2 = r_ctrl[6];
    assign m_coin1  = w_coin[0];
    assign m_coin2  = w_coin[1];
    assign pause    = r_pause;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Randomized and directed bench for arcade_input_ctrl against a cycle-count reference model.
module tb_arcade_input_ctrl;

    localparam int P = 4;
    localparam int G = 3;
    localparam int D = 10;
`ifdef INPUT_PAUSE_DIM_EN
    localparam bit DIM_EN = 1'b1;
`else
    localparam bit DIM_EN = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] joystick_0 = '0;
    logic [15:0] joystick_1 = '0;
    logic        osd_status = 1'b0;
    logic        osd_pause_dis = 1'b0;
    logic        hs_access = 1'b0;
    logic [7:0]  rgb_in = '0;
    logic        m_up, m_down, m_left, m_right, m_fire, m_start1, m_start2;
    logic        m_coin1, m_coin2, pause, dim_video;
    logic [7:0]  rgb_out;

    arcade_input_ctrl #(
        .COIN_PULSE (P),
        .COIN_GAP   (G),
        .DIM_TIMEOUT(D)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .joystick_0   (joystick_0),
        .joystick_1   (joystick_1),
        .osd_status   (osd_status),
        .osd_pause_dis(osd_pause_dis),
        .hs_access    (hs_access),
        .rgb_in       (rgb_in),
        .m_up         (m_up),
        .m_down       (m_down),
        .m_left       (m_left),
        .m_right      (m_right),
        .m_fire       (m_fire),
        .m_start1     (m_start1),
        .m_start2     (m_start2),
        .m_coin1      (m_coin1),
        .m_coin2      (m_coin2),
        .pause        (pause),
        .dim_video    (dim_video),
        .rgb_out      (rgb_out)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: cycle index, last accepted coin press per player, pause streak length
    int         cyc;
    int         acc[2];
    bit         prev_c[2];
    bit         armed[2];
    bit         tog;
    bit         prev_p;
    int         run;
    logic [6:0] e_ctrl;
    logic [1:0] e_coin;
    logic       e_pause;
    logic       e_dim;
    logic [7:0] e_rgb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] dimmed(input logic [7:0] v);
        int r, g, b;
        r = int'(v[7:5]);
        g = int'(v[4:2]);
        b = int'(v[1:0]);
        return 8'((r / 2) * 32 + (g / 2) * 4 + (b / 2));
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int p = 0; p < 2; p++) begin
            acc[p]    = -1000;
            prev_c[p] = 1'b0;
            armed[p]  = 1'b0;
        end
        tog     = 1'b0;
        prev_p  = 1'b0;
        run     = 0;
        e_ctrl  = '0;
        e_coin  = '0;
        e_pause = 1'b0;
        e_dim   = 1'b0;
        e_rgb   = '0;
    endtask

    task automatic model_step();
        logic [15:0] joy;
        bit          raw;
        bit          old_tog;
        if (!reset_n) begin
            return;
        end
        joy = joystick_0 | joystick_1;
        for (int p = 0; p < 2; p++) begin
            raw = (p == 0) ? joystick_0[7] : joystick_1[7];
            // a press is accepted only once the previous pulse plus lockout has fully elapsed
            if (raw && !prev_c[p] && armed[p] && (cyc > acc[p] + P + G)) begin
                acc[p] = cyc;
            end
            prev_c[p] = raw;
            if (!raw) armed[p] = 1'b1;
            e_coin[p] = (cyc + 1 > acc[p]) && (cyc + 1 <= acc[p] + P);
        end
        e_ctrl  = joy[6:0];
        e_rgb   = (DIM_EN && e_dim) ? dimmed(rgb_in) : rgb_in;
        old_tog = tog;
        if (joy[8] && !prev_p) tog = !tog;
        prev_p  = joy[8];
        e_pause = hs_access | tog | (osd_status & ~osd_pause_dis);
        run     = old_tog ? run + 1 : 0;
        e_dim   = DIM_EN && (run >= D);
        cyc++;
    endtask

    task automatic compare_all();
        check("ctrl", 32'({m_start2, m_start1, m_fire, m_up, m_down, m_left, m_right}), 32'(e_ctrl));
        check("coin1", 32'(m_coin1), 32'(e_coin[0]));
        check("coin2", 32'(m_coin2), 32'(e_coin[1]));
        check("pause", 32'(pause), 32'(e_pause));
        check("dim", 32'(dim_video), 32'(e_dim));
        check("rgb", 32'(rgb_out), 32'(e_rgb));
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            model_step();
            @(negedge clk_sys);
            compare_all();
        end
    endtask

    task automatic pulse_pause();
        joystick_0[8] = 1'b1;
        tick(1);
        joystick_0[8] = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        compare_all();
        @(negedge clk_sys);
        reset_n = 1'b1;
        tick(3);

        // held coin: exactly one 4-cycle pulse
        joystick_0[7] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            check("coin_held", 32'(m_coin1), 32'((k >= 1) && (k <= P)));
        end
        joystick_0[7] = 1'b0;
        tick(10);

        // lockout: presses at 0, 2, 6 give one pulse, press at 8 gives a second
        for (int k = 0; k < 14; k++) begin
            joystick_0[7] = (k == 0) || (k == 2) || (k == 6) || (k == 8);
            tick(1);
            check("coin_lock", 32'(m_coin1), 32'(((k + 1 >= 1) && (k + 1 <= 4)) || ((k + 1 >= 9) && (k + 1 <= 12))));
        end
        joystick_0[7] = 1'b0;
        tick(5);

        // pause and dim
        rgb_in = 8'hFF;
        pulse_pause();
        check("pause_on", 32'(pause), 32'd1);
        tick(12);
        check("dim_on", 32'(dim_video), 32'(DIM_EN));
        tick(1);
        check("rgb_dim", 32'(rgb_out), DIM_EN ? 32'h6D : 32'hFF);
        pulse_pause();
        tick(3);
        check("pause_off", 32'(pause), 32'd0);
        check("dim_off", 32'(dim_video), 32'd0);

        // OSD pause never dims
        osd_status = 1'b1;
        tick(30);
        check("osd_pause", 32'(pause), 32'd1);
        check("osd_nodim", 32'(dim_video), 32'd0);
        osd_pause_dis = 1'b1;
        tick(3);
        check("osd_dis", 32'(pause), 32'd0);
        osd_status = 1'b0;
        osd_pause_dis = 1'b0;
        tick(2);

        // reset during a coin pulse and a dimmed pause, coin held through reset
        pulse_pause();
        tick(8);
        joystick_1[7] = 1'b1;
        tick(3);
        check("pre_rst_coin2", 32'(m_coin2), 32'd1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_async_coin2", 32'(m_coin2), 32'd0);
        tick(2);
        @(negedge clk_sys);
        reset_n = 1'b1;
        tick(10);
        check("held_no_coin", 32'(m_coin2), 32'd0);
        joystick_1[7] = 1'b0;
        tick(2);
        joystick_1[7] = 1'b1;
        tick(1);
        check("repress_coin", 32'(m_coin2), 32'd1);
        joystick_1[7] = 1'b0;
        tick(10);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            joystick_0    = 16'($urandom);
            joystick_1    = 16'($urandom);
            joystick_0[8] = ($urandom_range(0, 39) == 0);
            joystick_1[8] = 1'b0;
            joystick_0[7] = ($urandom_range(0, 3) == 0);
            joystick_1[7] = ($urandom_range(0, 2) == 0);
            osd_status    = ($urandom_range(0, 7) == 0);
            osd_pause_dis = ($urandom_range(0, 1) == 0);
            hs_access     = ($urandom_range(0, 9) == 0);
            rgb_in        = 8'($urandom);
            tick(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
